// File: rtl/uart_cmd_responder.sv
// rtl/uart_cmd_responder.sv - UART byte command decoder driving a 32-bit register bus
module uart_cmd_responder #(
  parameter int RX_TIMEOUT  = 200000,
  parameter int BUS_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        bus_req,
  output logic        bus_we,
  output logic [7:0]  bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        busy,
  output logic        err
);
  localparam logic [7:0]  OP_WRITE  = 8'h57;
  localparam logic [7:0]  OP_READ   = 8'h52;
  localparam logic [7:0]  RSP_OK    = 8'h4B;
  localparam logic [7:0]  RSP_BADOP = 8'h3F;
  localparam logic [7:0]  RSP_BUSTO = 8'h45;
  localparam logic [31:0] RX_LAST   = 32'(RX_TIMEOUT - 1);
  localparam logic [31:0] BUS_LAST  = 32'(BUS_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, BUS, SEND, TX_WAIT_HI, TX_WAIT_LO
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  // Outgoing bytes always leave from resp[31:24]; the register shifts left per byte.
  logic [31:0] resp;
  logic [1:0]  data_idx;
  logic [1:0]  byte_idx;
  logic [1:0]  last_idx;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      resp      <= '0;
      data_idx  <= '0;
      byte_idx  <= '0;
      last_idx  <= '0;
      tx_data   <= '0;
      tx_start  <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      err       <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      err      <= 1'b0;
      if (rx_ready && (state == BUS || state == SEND || state == TX_WAIT_HI || state == TX_WAIT_LO))
        err <= 1'b1;

      case (state)
        IDLE: begin
          if (rx_ready) begin
            byte_idx <= '0;
            if (rx_data == OP_WRITE || rx_data == OP_READ) begin
              bus_we <= (rx_data == OP_WRITE);
              cnt    <= '0;
              state  <= GET_ADDR;
            end else begin
              resp     <= {RSP_BADOP, 24'h0};
              last_idx <= 2'd0;
              err      <= 1'b1;
              state    <= SEND;
            end
          end
        end
        GET_ADDR: begin
          if (rx_ready) begin
            bus_addr <= rx_data;
            cnt      <= '0;
            if (bus_we) begin
              data_idx <= '0;
              state    <= GET_DATA;
            end else begin
              bus_req <= 1'b1;
              state   <= BUS;
            end
          end else if (cnt == RX_LAST) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        GET_DATA: begin
          if (rx_ready) begin
            bus_wdata <= {bus_wdata[23:0], rx_data};
            cnt       <= '0;
            if (data_idx == 2'd3) begin
              bus_req <= 1'b1;
              state   <= BUS;
            end else begin
              data_idx <= data_idx + 2'd1;
            end
          end else if (cnt == RX_LAST) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        BUS: begin
          // An ack arriving on the timeout cycle still wins.
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (bus_we) begin
              resp     <= {RSP_OK, 24'h0};
              last_idx <= 2'd0;
            end else begin
              resp     <= bus_rdata;
              last_idx <= 2'd3;
            end
            state <= SEND;
          end else if (cnt == BUS_LAST) begin
            bus_req  <= 1'b0;
            resp     <= {RSP_BUSTO, 24'h0};
            last_idx <= 2'd0;
            err      <= 1'b1;
            state    <= SEND;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_data  <= resp[31:24];
            tx_start <= 1'b1;
            state    <= TX_WAIT_HI;
          end
        end
        TX_WAIT_HI: begin
          if (tx_busy) state <= TX_WAIT_LO;
        end
        TX_WAIT_LO: begin
          if (!tx_busy) begin
            if (byte_idx != last_idx) begin
              byte_idx <= byte_idx + 2'd1;
              resp     <= {resp[23:0], 8'h00};
              state    <= SEND;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb/tb_uart_cmd_responder.sv - randomized bench for uart_cmd_responder with a reference model
module tb_uart_cmd_responder;
  localparam int RX_TO  = 50;
  localparam int BUS_TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic        bus_req;
  logic        bus_we;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_ack = 1'b0;
  logic        busy;
  logic        err;

  uart_cmd_responder #(.RX_TIMEOUT(RX_TO), .BUS_TIMEOUT(BUS_TO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          ack_lat = -1;
  logic [31:0] rd_val = 32'h0;
  logic        tx_block = 1'b0;
  logic [7:0]  tx_q[$];
  logic        bus_we_q[$];
  logic [7:0]  bus_addr_q[$];
  logic [31:0] bus_wdata_q[$];
  int          req_cnt = 0;
  int          last_req_len = 0;
  int          err_cnt = 0;
  int          busy_left = 0;
  logic [7:0]  cur_tx = 8'h00;
  logic [7:0]  cmd_q[$];

  // UART transmitter model: busy for a random 1..4 cycles after each accepted start.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin
        checks++;
        if (tx_busy !== 1'b0) begin
          errors++;
          $display("FAIL tx_start_while_busy: tx_busy=%b required 0", tx_busy);
        end
        tx_q.push_back(tx_data);
        cur_tx = tx_data;
        busy_left = $urandom_range(1, 4);
      end else if (busy_left > 0) begin
        checks++;
        if (tx_data !== cur_tx) begin
          errors++;
          $display("FAIL tx_data_hold: got %02h required %02h", tx_data, cur_tx);
        end
        busy_left--;
      end
      tx_busy = tx_block || (busy_left > 0);
    end
  end

  // Register bus model: acks ack_lat cycles after the first cycle bus_req is seen.
  initial begin
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      bus_rdata = $urandom;
      if (bus_req) begin
        if (req_cnt == 0) begin
          bus_we_q.push_back(bus_we);
          bus_addr_q.push_back(bus_addr);
          bus_wdata_q.push_back(bus_wdata);
        end
        if (req_cnt == ack_lat) begin
          bus_ack = 1'b1;
          bus_rdata = rd_val;
        end
        req_cnt++;
      end else if (req_cnt != 0) begin
        last_req_len = req_cnt;
        req_cnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (err) err_cnt++;
    end
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic clear_obs();
    tx_q.delete();
    bus_we_q.delete();
    bus_addr_q.delete();
    bus_wdata_q.delete();
    last_req_len = 0;
    err_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b required 0 after %0d cycles", name, busy, n);
    end
  endtask

  // Sends cmd_q and compares everything observed against the protocol rules.
  task automatic run_cmd(input string name, input int lat, input logic [31:0] rd);
    logic [7:0]  exp_tx[$];
    logic [7:0]  op;
    logic        exp_we;
    logic [31:0] exp_wd;
    int          exp_bus;
    int          exp_err;
    int          exp_len;
    clear_obs();
    ack_lat = lat;
    rd_val = rd;
    op = cmd_q[0];
    exp_bus = 0;
    exp_err = 0;
    exp_len = 0;
    exp_we = (op == 8'h57);
    exp_wd = 32'h0;
    if (op != 8'h57 && op != 8'h52) begin
      exp_tx.push_back(8'h3F);
      exp_err = 1;
    end else begin
      exp_bus = 1;
      if (exp_we) exp_wd = {cmd_q[2], cmd_q[3], cmd_q[4], cmd_q[5]};
      if (lat >= 0 && lat < BUS_TO) begin
        exp_len = lat + 1;
        if (exp_we) exp_tx.push_back(8'h4B);
        else for (int i = 0; i < 4; i++) exp_tx.push_back(8'(rd >> (24 - 8 * i)));
      end else begin
        exp_len = BUS_TO;
        exp_tx.push_back(8'h45);
        exp_err = 1;
      end
    end

    foreach (cmd_q[i]) begin
      send_byte(cmd_q[i]);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle(name);
    repeat (2) @(negedge clk);

    checks++;
    if (tx_q.size() != exp_tx.size()) begin
      errors++;
      $display("FAIL %s_tx_count: got %0d required %0d", name, tx_q.size(), exp_tx.size());
    end
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++) begin
      checks++;
      if (tx_q[i] !== exp_tx[i]) begin
        errors++;
        $display("FAIL %s_tx_byte%0d: got %02h required %02h", name, i, tx_q[i], exp_tx[i]);
      end
    end
    checks++;
    if (bus_addr_q.size() != exp_bus) begin
      errors++;
      $display("FAIL %s_bus_count: got %0d required %0d", name, bus_addr_q.size(), exp_bus);
    end
    if (exp_bus == 1 && bus_addr_q.size() > 0) begin
      checks++;
      if (bus_we_q[0] !== exp_we || bus_addr_q[0] !== cmd_q[1]) begin
        errors++;
        $display("FAIL %s_bus_cmd: we=%b addr=%02h required we=%b addr=%02h",
                 name, bus_we_q[0], bus_addr_q[0], exp_we, cmd_q[1]);
      end
      if (exp_we) begin
        checks++;
        if (bus_wdata_q[0] !== exp_wd) begin
          errors++;
          $display("FAIL %s_bus_wdata: got %08h required %08h", name, bus_wdata_q[0], exp_wd);
        end
      end
      checks++;
      if (last_req_len != exp_len) begin
        errors++;
        $display("FAIL %s_req_len: got %0d required %0d", name, last_req_len, exp_len);
      end
    end
    checks++;
    if (err_cnt != exp_err) begin
      errors++;
      $display("FAIL %s_err_count: got %0d required %0d", name, err_cnt, exp_err);
    end
  endtask

  task automatic set_write(input logic [7:0] a, input logic [31:0] d);
    cmd_q.delete();
    cmd_q.push_back(8'h57);
    cmd_q.push_back(a);
    for (int i = 0; i < 4; i++) cmd_q.push_back(8'(d >> (24 - 8 * i)));
  endtask

  task automatic set_read(input logic [7:0] a);
    cmd_q.delete();
    cmd_q.push_back(8'h52);
    cmd_q.push_back(a);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({tx_start, bus_req, bus_we, busy, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000", {tx_start, bus_req, bus_we, busy, err});
    end
    checks++;
    if ({tx_data, bus_addr, bus_wdata} !== 48'h0) begin
      errors++;
      $display("FAIL reset_data: got %012h required 0", {tx_data, bus_addr, bus_wdata});
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    set_write(8'h10, 32'hDEADBEEF);
    run_cmd("write", 3, 32'h0);
    set_write(8'hFF, 32'h00000001);
    run_cmd("write_late_ack", BUS_TO - 1, 32'h0);
  endtask

  task automatic test_read();
    set_read(8'h04);
    run_cmd("read", 1, 32'h12345678);
    set_read(8'h00);
    run_cmd("read_fast", 0, 32'hA5C3_0F81);
  endtask

  task automatic test_unknown_opcode();
    cmd_q.delete();
    cmd_q.push_back(8'hAA);
    run_cmd("unknown", 0, 32'h0);
    set_read(8'h08);
    run_cmd("after_unknown", 2, 32'hCAFEF00D);
  endtask

  task automatic test_rx_timeout();
    int cyc = 1;
    clear_obs();
    send_byte(8'h57);
    send_byte(8'h01);
    while (!err && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != RX_TO + 1) begin
      errors++;
      $display("FAIL rx_timeout_delay: err after %0d cycles required %0d", cyc - 1, RX_TO);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rx_timeout_idle: busy=%b required 0", busy);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (tx_q.size() != 0 || bus_addr_q.size() != 0) begin
      errors++;
      $display("FAIL rx_timeout_quiet: tx=%0d bus=%0d required 0 0", tx_q.size(), bus_addr_q.size());
    end
  endtask

  task automatic test_bus_timeout();
    set_read(8'h20);
    run_cmd("bus_timeout", -1, 32'h0);
  endtask

  task automatic test_overrun();
    logic [31:0] rd = $urandom;
    clear_obs();
    ack_lat = 0;
    rd_val = rd;
    tx_block = 1'b1;
    send_byte(8'h52);
    send_byte(8'h30);
    repeat (4) @(negedge clk);
    send_byte(8'hC3);
    repeat (3) @(negedge clk);
    checks++;
    if (err_cnt != 1 || tx_q.size() != 0) begin
      errors++;
      $display("FAIL overrun_err: err=%0d tx=%0d required 1 0", err_cnt, tx_q.size());
    end
    tx_block = 1'b0;
    wait_idle("overrun");
    repeat (2) @(negedge clk);
    checks++;
    if (tx_q.size() != 4) begin
      errors++;
      $display("FAIL overrun_tx_count: got %0d required 4", tx_q.size());
    end
    for (int i = 0; i < 4 && i < tx_q.size(); i++) begin
      checks++;
      if (tx_q[i] !== 8'(rd >> (24 - 8 * i))) begin
        errors++;
        $display("FAIL overrun_tx_byte%0d: got %02h required %02h", i, tx_q[i], 8'(rd >> (24 - 8 * i)));
      end
    end
    checks++;
    if (err_cnt != 1) begin
      errors++;
      $display("FAIL overrun_err_total: got %0d required 1", err_cnt);
    end
  endtask

  task automatic test_reset_mid_bus();
    clear_obs();
    ack_lat = -1;
    send_byte(8'h52);
    send_byte(8'h40);
    repeat (3) @(negedge clk);
    checks++;
    if (bus_req !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: bus_req=%b required 1", bus_req);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus_req, tx_start, busy, err} !== 4'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got %b required 0000", {bus_req, tx_start, busy, err});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    set_write(8'h44, 32'h0BAD_F00D);
    run_cmd("after_reset", 2, 32'h0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int kind = $urandom_range(0, 2);
      int lat = $urandom_range(0, BUS_TO);
      logic [7:0] b;
      if (kind == 0) set_write(8'($urandom), $urandom);
      else if (kind == 1) set_read(8'($urandom));
      else begin
        b = 8'($urandom);
        if (b == 8'h57 || b == 8'h52) b = 8'h00;
        cmd_q.delete();
        cmd_q.push_back(b);
      end
      run_cmd($sformatf("rand%0d", n), lat, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_unknown_opcode();
    test_rx_timeout();
    test_bus_timeout();
    test_overrun();
    test_reset_mid_bus();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
